// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: packet-aware 1-to-2 stream demultiplexer.
// The input stream is steered to lane A or lane B by sel_i, which is only
// looked at on the first beat of a packet; the chosen lane then stays locked
// until the last beat, so a packet never straddles both lanes. Each lane has a
// one-deep registered output stage and a wrapping completed-packet counter.
module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              sel_i,
  output logic              in_ready_o,
  output logic              a_valid_o,
  output logic [DATA_W-1:0] a_data_o,
  output logic              a_last_o,
  input  logic              a_ready_i,
  output logic              b_valid_o,
  output logic [DATA_W-1:0] b_data_o,
  output logic              b_last_o,
  input  logic              b_ready_i,
  output logic [CNT_W-1:0]  a_pkt_cnt_o,
  output logic [CNT_W-1:0]  b_pkt_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state;

  logic tgt_b;
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // Pick the target lane: sel_i while no packet is open, the locked lane otherwise.
  // Ready is combinational so a lane that is being drained can be refilled in
  // the same cycle, giving one beat per cycle under a ready consumer.
  always_comb begin
    tgt_b      = (state == IDLE) ? sel_i : (state == LOCK_B);
    tgt_valid  = tgt_b ? b_valid_o : a_valid_o;
    tgt_ready  = tgt_b ? b_ready_i : a_ready_i;
    in_ready_o = ~reset & (~tgt_valid | tgt_ready);
    accept     = in_valid_i & in_ready_o;
    load_a     = accept & ~tgt_b;
    load_b     = accept & tgt_b;
    drain_a    = a_valid_o & a_ready_i;
    drain_b    = b_valid_o & b_ready_i;
  end

  // Packet lock FSM: opens a lock on a non-final first beat, releases on the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last_i) begin
            state <= sel_i ? LOCK_B : LOCK_A;
          end
        end
        LOCK_A, LOCK_B: begin
          if (in_last_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane A output register: a load wins over a drain so a simultaneous refill keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_o <= 1'b0;
      a_data_o  <= '0;
      a_last_o  <= 1'b0;
    end else if (load_a) begin
      a_valid_o <= 1'b1;
      a_data_o  <= in_data_i;
      a_last_o  <= in_last_i;
    end else if (drain_a) begin
      a_valid_o <= 1'b0;
    end
  end

  // Lane B output register, same behaviour as lane A.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid_o <= 1'b0;
      b_data_o  <= '0;
      b_last_o  <= 1'b0;
    end else if (load_b) begin
      b_valid_o <= 1'b1;
      b_data_o  <= in_data_i;
      b_last_o  <= in_last_i;
    end else if (drain_b) begin
      b_valid_o <= 1'b0;
    end
  end

  // Completed-packet counters: count the last beat as it leaves each lane, wrapping freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_pkt_cnt_o <= '0;
      b_pkt_cnt_o <= '0;
    end else begin
      if (drain_a && a_last_o) begin
        a_pkt_cnt_o <= a_pkt_cnt_o + CNT_W'(1);
      end
      if (drain_b && b_last_o) begin
        b_pkt_cnt_o <= b_pkt_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: scoreboard bench for the 1-to-2 packet demultiplexer.
// Stimulus pushes each accepted beat into the queue of the lane it must
// appear on; a monitor pops and compares whenever a lane completes a transfer.
module tb_stream_demux_1to2;

  logic       clk;
  logic       reset;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_last_i;
  logic       sel_i;
  logic       in_ready_o;
  logic       a_valid_o;
  logic [7:0] a_data_o;
  logic       a_last_o;
  logic       a_ready_i;
  logic       b_valid_o;
  logic [7:0] b_data_o;
  logic       b_last_o;
  logic       b_ready_i;
  logic [7:0] a_pkt_cnt_o;
  logic [7:0] b_pkt_cnt_o;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  beat_t exp_a;
  beat_t exp_b;

  int checks = 0;
  int errors = 0;
  int w;

  stream_demux_1to2 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_last_i(in_last_i),
    .sel_i(sel_i),
    .in_ready_o(in_ready_o),
    .a_valid_o(a_valid_o),
    .a_data_o(a_data_o),
    .a_last_o(a_last_o),
    .a_ready_i(a_ready_i),
    .b_valid_o(b_valid_o),
    .b_data_o(b_data_o),
    .b_last_o(b_last_o),
    .b_ready_i(b_ready_i),
    .a_pkt_cnt_o(a_pkt_cnt_o),
    .b_pkt_cnt_o(b_pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one beat and wait for its handshake; the beat is queued on the lane it must reach.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic s,
                               input logic exp_lane_b, output int waits);
    beat_t e;
    waits = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    sel_i      = s;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid_i = 1'b0;
    end else begin
      e.d = d;
      e.l = l;
      if (exp_lane_b) qb.push_back(e);
      else qa.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    in_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every completed lane transfer must match the head of that lane's queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_valid_o && a_ready_i) begin
        if (qa.size() == 0) begin
          checkOutput("laneA_unexpected_beat", int'(a_data_o), -1);
        end else begin
          exp_a = qa.pop_front();
          checkOutput("laneA_data", int'(a_data_o), int'(exp_a.d));
          checkOutput("laneA_last", int'(a_last_o), int'(exp_a.l));
        end
      end
      if (b_valid_o && b_ready_i) begin
        if (qb.size() == 0) begin
          checkOutput("laneB_unexpected_beat", int'(b_data_o), -1);
        end else begin
          exp_b = qb.pop_front();
          checkOutput("laneB_data", int'(b_data_o), int'(exp_b.d));
          checkOutput("laneB_last", int'(b_last_o), int'(exp_b.l));
        end
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'hEE;
    in_last_i  = 1'b0;
    sel_i      = 1'b0;
    a_ready_i  = 1'b1;
    b_ready_i  = 1'b1;

    // Reset held two cycles with a pending input beat.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", int'(in_ready_o), 0);
    end
    checkOutput("rst_a_valid", int'(a_valid_o), 0);
    checkOutput("rst_b_valid", int'(b_valid_o), 0);
    checkOutput("rst_a_data", int'(a_data_o), 0);
    checkOutput("rst_b_data", int'(b_data_o), 0);
    checkOutput("rst_a_last", int'(a_last_o), 0);
    checkOutput("rst_b_last", int'(b_last_o), 0);
    checkOutput("rst_a_cnt", int'(a_pkt_cnt_o), 0);
    checkOutput("rst_b_cnt", int'(b_pkt_cnt_o), 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", int'(in_ready_o), 1);
    @(posedge clk);
    #1;

    // Single-beat routing with one-cycle latency.
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, w);
    checkOutput("lat_a_valid", int'(a_valid_o), 1);
    checkOutput("lat_a_data", int'(a_data_o), 8'h5A);
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, w);
    checkOutput("lat_b_valid", int'(b_valid_o), 1);
    checkOutput("lat_b_data", int'(b_data_o), 8'hA5);
    idleCycles(2);
    checkOutput("single_a_cnt", int'(a_pkt_cnt_o), 1);
    checkOutput("single_b_cnt", int'(b_pkt_cnt_o), 1);

    // Packet lock: sel_i toggles mid-packet but the whole packet stays on A.
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b0, w);
    applyStimulus(8'h33, 1'b1, 1'b1, 1'b0, w);
    applyStimulus(8'h44, 1'b0, 1'b1, 1'b1, w);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b1, w);
    idleCycles(2);
    checkOutput("lock_a_cnt", int'(a_pkt_cnt_o), 2);
    checkOutput("lock_b_cnt", int'(b_pkt_cnt_o), 2);

    // Backpressure on A while B drains an earlier beat.
    b_ready_i = 1'b0;
    applyStimulus(8'h70, 1'b1, 1'b1, 1'b1, w);
    in_valid_i = 1'b0;
    a_ready_i  = 1'b0;
    applyStimulus(8'h61, 1'b0, 1'b0, 1'b0, w);
    in_valid_i = 1'b1;
    in_data_i  = 8'h62;
    in_last_i  = 1'b0;
    sel_i      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", int'(in_ready_o), 0);
      checkOutput("bp_a_valid", int'(a_valid_o), 1);
      checkOutput("bp_a_data", int'(a_data_o), 8'h61);
      @(posedge clk);
      #1;
      if (i == 0) b_ready_i = 1'b1;
    end
    checkOutput("bp_b_drained", int'(b_valid_o), 0);
    checkOutput("bp_b_cnt", int'(b_pkt_cnt_o), 3);
    a_ready_i = 1'b1;
    applyStimulus(8'h62, 1'b0, 1'b1, 1'b0, w);
    checkOutput("bp_resume_wait0", w, 0);
    applyStimulus(8'h63, 1'b0, 1'b0, 1'b0, w);
    checkOutput("bp_resume_wait1", w, 0);
    applyStimulus(8'h64, 1'b1, 1'b1, 1'b0, w);
    checkOutput("bp_resume_wait2", w, 0);
    idleCycles(2);
    checkOutput("bp_a_cnt", int'(a_pkt_cnt_o), 3);

    // Counter wrap on lane B starting from a fresh reset.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b1, 1'b1, w);
    end
    idleCycles(2);
    checkOutput("wrap_b_cnt_255", int'(b_pkt_cnt_o), 255);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1, w);
    idleCycles(2);
    checkOutput("wrap_b_cnt_0", int'(b_pkt_cnt_o), 0);
    checkOutput("wrap_a_cnt", int'(a_pkt_cnt_o), 0);

    // Reset in the middle of a 4-beat lane-A packet discards the held beat and the lock.
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(8'h82, 1'b0, 1'b0, 1'b0, w);
    in_valid_i = 1'b0;
    reset = 1'b1;
    qa.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sel_i = 1'b1;
    @(negedge clk);
    checkOutput("midrst_a_valid", int'(a_valid_o), 0);
    checkOutput("midrst_in_ready", int'(in_ready_o), 1);
    @(posedge clk);
    #1;
    applyStimulus(8'h91, 1'b1, 1'b1, 1'b1, w);
    checkOutput("midrst_b_valid", int'(b_valid_o), 1);
    checkOutput("midrst_a_idle", int'(a_valid_o), 0);
    idleCycles(2);
    checkOutput("midrst_b_cnt", int'(b_pkt_cnt_o), 1);

    checkOutput("end_qa_empty", qa.size(), 0);
    checkOutput("end_qb_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
